// File: rtl/ascon_ctrl_fsm_pkg.sv
// Shared types and constants for the ASCON-128 control FSM.
package ascon_ctrl_fsm_pkg;

  // Permutation rounds always end on index 11; a phase of N rounds starts at 12-N.
  localparam int          ROUND_CNT     = 12;
  localparam logic [3:0]  ROUND_LAST    = 4'd11;
  localparam logic [3:0]  ROUND_START_A = 4'd0;
  localparam logic [3:0]  ROUND_START_B = 4'd6;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INIT    = 3'd1,
    ST_WAIT_AD = 3'd2,
    ST_AD_PERM = 3'd3,
    ST_WAIT_PT = 3'd4,
    ST_PT_PERM = 3'd5,
    ST_FINAL   = 3'd6,
    ST_END     = 3'd7
  } state_t;

  // First round index of a phase with the given number of rounds.
  function automatic logic [3:0] round_start(input int rounds);
    return 4'(ROUND_CNT - rounds);
  endfunction

endpackage

// File: rtl/ascon_ctrl_fsm_round_counter.sv
// Round index counter: loadable at phase entry, flags the final round (11).
module ascon_ctrl_fsm_round_counter
  import ascon_ctrl_fsm_pkg::*;
(
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       load,
  input  logic [3:0] load_value,
  input  logic       enable,
  output logic [3:0] count,
  output logic       last
);

  // Load has priority over increment; the FSM never enables past the last round.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      count <= ROUND_START_A;
    end else if (load) begin
      count <= load_value;
    end else if (enable) begin
      count <= count + 4'd1;
    end
  end

  assign last = (count == ROUND_LAST);

endmodule

// File: rtl/ascon_ctrl_fsm.sv
// ASCON-128 AEAD control FSM driving the permutation/XOR datapath.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for start_i, all outputs low
// INIT     | initialization permutation p^a, first round loads IV||K||N
// WAIT_AD  | ready for an associated-data block
// AD_PERM  | remaining p^b rounds of an AD block
// WAIT_PT  | ready for a plaintext block
// PT_PERM  | remaining p^b rounds of a non-final PT block
// FINAL    | finalization permutation p^a after the last PT block
// END      | one-cycle tag_valid_o, then back to IDLE
module ascon_ctrl_fsm
  import ascon_ctrl_fsm_pkg::*;
#(
  parameter int ROUNDS_A = 12,
  parameter int ROUNDS_B = 6
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       data_valid_i,
  input  logic       data_last_i,
  output logic       data_ready_o,
  output logic       sel_o,
  output logic       en_reg_o,
  output logic [3:0] round_o,
  output logic       en_xor_data_o,
  output logic       en_xor_key_begin_o,
  output logic       en_xor_key_end_o,
  output logic       en_xor_lsb_o,
  output logic       en_cypher_o,
  output logic       en_tag_o,
  output logic       cypher_valid_o,
  output logic       tag_valid_o,
  output logic       busy_o
);

  localparam logic [3:0] START_A      = round_start(ROUNDS_A);
  localparam logic [3:0] START_B      = round_start(ROUNDS_B);
  localparam logic [3:0] START_A_NEXT = 4'(START_A + 4'd1);
  localparam logic [3:0] START_B_NEXT = 4'(START_B + 4'd1);

  state_t     state_q;
  state_t     state_d;
  logic       last_ad_q;
  logic       cypher_valid_q;
  logic       ad_accept;
  logic       pt_accept;
  logic       cnt_load;
  logic [3:0] cnt_load_value;
  logic       cnt_enable;
  logic [3:0] cnt_value;
  logic       cnt_last;

  ascon_ctrl_fsm_round_counter u_round_counter (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .enable     (cnt_enable),
    .count      (cnt_value),
    .last       (cnt_last)
  );

  assign ad_accept = (state_q == ST_WAIT_AD) && data_valid_i;
  assign pt_accept = (state_q == ST_WAIT_PT) && data_valid_i;

  // State register; reset wins over every other input.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // last_ad is captured with the AD block; cipher-valid trails each PT accept by one cycle.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      last_ad_q      <= 1'b0;
      cypher_valid_q <= 1'b0;
    end else begin
      if (ad_accept) begin
        last_ad_q <= data_last_i;
      end
      cypher_valid_q <= pt_accept;
    end
  end

  // Next-state, counter control and datapath enables.
  always_comb begin
    state_d            = state_q;
    cnt_load           = 1'b0;
    cnt_load_value     = START_A;
    cnt_enable         = 1'b0;
    data_ready_o       = 1'b0;
    sel_o              = 1'b0;
    en_reg_o           = 1'b0;
    round_o            = 4'd0;
    en_xor_data_o      = 1'b0;
    en_xor_key_begin_o = 1'b0;
    en_xor_key_end_o   = 1'b0;
    en_xor_lsb_o       = 1'b0;
    en_cypher_o        = 1'b0;
    en_tag_o           = 1'b0;
    tag_valid_o        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          cnt_load       = 1'b1;
          cnt_load_value = START_A;
          state_d        = ST_INIT;
        end
      end

      ST_INIT: begin
        en_reg_o = 1'b1;
        sel_o    = (cnt_value != START_A);
        round_o  = cnt_value;
        if (cnt_last) begin
          en_xor_key_end_o = 1'b1;
          state_d          = ST_WAIT_AD;
        end else begin
          cnt_enable = 1'b1;
        end
      end

      ST_WAIT_AD: begin
        data_ready_o = 1'b1;
        if (data_valid_i) begin
          en_reg_o       = 1'b1;
          sel_o          = 1'b1;
          en_xor_data_o  = 1'b1;
          round_o        = START_B;
          cnt_load       = 1'b1;
          cnt_load_value = START_B_NEXT;
          state_d        = ST_AD_PERM;
        end
      end

      ST_AD_PERM: begin
        en_reg_o = 1'b1;
        sel_o    = 1'b1;
        round_o  = cnt_value;
        if (cnt_last) begin
          en_xor_lsb_o = last_ad_q;
          state_d      = last_ad_q ? ST_WAIT_PT : ST_WAIT_AD;
        end else begin
          cnt_enable = 1'b1;
        end
      end

      ST_WAIT_PT: begin
        data_ready_o = 1'b1;
        if (data_valid_i) begin
          en_reg_o      = 1'b1;
          sel_o         = 1'b1;
          en_xor_data_o = 1'b1;
          en_cypher_o   = 1'b1;
          cnt_load      = 1'b1;
          if (data_last_i) begin
            // Last block goes straight into finalization: key XOR before p^a.
            en_xor_key_begin_o = 1'b1;
            round_o            = START_A;
            cnt_load_value     = START_A_NEXT;
            state_d            = ST_FINAL;
          end else begin
            round_o        = START_B;
            cnt_load_value = START_B_NEXT;
            state_d        = ST_PT_PERM;
          end
        end
      end

      ST_PT_PERM: begin
        en_reg_o = 1'b1;
        sel_o    = 1'b1;
        round_o  = cnt_value;
        if (cnt_last) begin
          state_d = ST_WAIT_PT;
        end else begin
          cnt_enable = 1'b1;
        end
      end

      ST_FINAL: begin
        en_reg_o = 1'b1;
        sel_o    = 1'b1;
        round_o  = cnt_value;
        if (cnt_last) begin
          en_xor_key_end_o = 1'b1;
          en_tag_o         = 1'b1;
          state_d          = ST_END;
        end else begin
          cnt_enable = 1'b1;
        end
      end

      ST_END: begin
        tag_valid_o = 1'b1;
        state_d     = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy_o         = (state_q != ST_IDLE);
  assign cypher_valid_o = cypher_valid_q;

endmodule
